// File: rtl/mat_row_mem.sv
// Row-organised complex-matrix store for the lu engine.
// Loaded row by row from the host, serves single-cycle row reads and write-backs, then streams its contents out.
module mat_row_mem #(
    parameter  int SIZE  = 32,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(SIZE),
    localparam int ROW_W = SIZE * 2 * WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [ROW_W-1:0] load_row_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             full_o,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic             rd_addr_valid_i,
    output logic [ROW_W-1:0] mat_row_o,
    output logic             mat_row_valid_o,
    output logic [AW-1:0]    mat_row_addr_o,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic             dump_start_i,
    output logic [ROW_W-1:0] dump_row_o,
    output logic [AW-1:0]    dump_addr_o,
    output logic             dump_valid_o,
    input  logic             dump_ready_i
);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DUMP} state_e;

    localparam logic [AW:0] LAST_ROW = (AW+1)'(SIZE - 1);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] SIZE_W   = (AW+1)'(SIZE);

    state_e           state_q, state_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             load_we, wr_we, rd_fire;
    logic             rd_ok, wr_ok;
    logic [ROW_W-1:0] mem [SIZE];
    logic [ROW_W-1:0] mat_row_q;
    logic [AW-1:0]    mat_row_addr_q;
    logic             mat_row_valid_q;

    // A power-of-two SIZE makes every address in range, so skip the compare entirely.
    if ((1 << AW) == SIZE) begin : g_pow2
        assign rd_ok = 1'b1;
        assign wr_ok = 1'b1;
    end else begin : g_npow2
        assign rd_ok = ({1'b0, rd_addr_i} < SIZE_W);
        assign wr_ok = ({1'b0, wr_addr_i} < SIZE_W);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_we = 1'b0;
        wr_we   = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid_i) begin
                        load_we = 1'b1;
                        cnt_d   = ONE;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (load_valid_i) begin
                        load_we = 1'b1;
                        if (cnt_q == LAST_ROW) begin
                            state_d = SERVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
                SERVE: begin
                    wr_we = wr_valid_i && wr_ok;
                    if (dump_start_i) begin
                        state_d = DUMP;
                        cnt_d   = '0;
                    end
                end
                DUMP: begin
                    if (dump_ready_i) begin
                        if (cnt_q == LAST_ROW) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready_o = (state_q == IDLE) || (state_q == LOAD);
        full_o       = (state_q == SERVE) || (state_q == DUMP);
        wr_ready_o   = (state_q == SERVE);
        dump_valid_o = (state_q == DUMP);
        dump_addr_o  = '0;
        dump_row_o   = '0;
        if (state_q == DUMP) begin
            dump_addr_o = cnt_q[AW-1:0];
            dump_row_o  = mem[cnt_q[AW-1:0]];
        end
    end

    // Memory has no reset; nonblocking writes give read-before-write on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (load_we) begin
            mem[cnt_q[AW-1:0]] <= load_row_i;
        end else if (wr_we) begin
            mem[wr_addr_i] <= wr_row_i;
        end
    end

    assign rd_fire = (state_q == SERVE) && rd_addr_valid_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mat_row_valid_q <= 1'b0;
            mat_row_q       <= '0;
            mat_row_addr_q  <= '0;
        end else begin
            mat_row_valid_q <= rd_fire;
            if (rd_fire) begin
                mat_row_addr_q <= rd_addr_i;
                mat_row_q      <= rd_ok ? mem[rd_addr_i] : '0;
            end
        end
    end

    assign mat_row_o       = mat_row_q;
    assign mat_row_addr_o  = mat_row_addr_q;
    assign mat_row_valid_o = mat_row_valid_q;

endmodule

// File: tb/tb_mat_row_mem.sv
// Scoreboard bench for mat_row_mem: directed loads, reads, write-backs, dumps, flushes and resets.
// Expected read/dump rows are queued at issue time and checked by an independent monitor.
module tb_mat_row_mem;

    localparam int SIZE  = 32;
    localparam int WIDTH = 64;
    localparam int AW    = 5;
    localparam int ROW_W = SIZE * 2 * WIDTH;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [ROW_W-1:0] data;
    } resp_t;

    logic             clk = 1'b0;
    logic             rstN;
    logic             flush;
    logic [ROW_W-1:0] loadRowIn;
    logic             loadValid;
    logic             loadReady;
    logic             full;
    logic [AW-1:0]    rdAddr;
    logic             rdAddrValid;
    logic [ROW_W-1:0] matRow;
    logic             matRowValid;
    logic [AW-1:0]    matRowAddr;
    logic [ROW_W-1:0] wrRow;
    logic [AW-1:0]    wrAddr;
    logic             wrValid;
    logic             wrReady;
    logic             dumpStart;
    logic [ROW_W-1:0] dumpRow;
    logic [AW-1:0]    dumpAddr;
    logic             dumpValid;
    logic             dumpReady;

    resp_t            rdQ[$];
    resp_t            dumpQ[$];
    logic [ROW_W-1:0] model [SIZE];
    int               total = 0;
    int               bad = 0;

    mat_row_mem #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i(clk), .rst_ni(rstN), .flush_i(flush),
        .load_row_i(loadRowIn), .load_valid_i(loadValid), .load_ready_o(loadReady),
        .full_o(full),
        .rd_addr_i(rdAddr), .rd_addr_valid_i(rdAddrValid),
        .mat_row_o(matRow), .mat_row_valid_o(matRowValid), .mat_row_addr_o(matRowAddr),
        .wr_row_i(wrRow), .wr_addr_i(wrAddr), .wr_valid_i(wrValid), .wr_ready_o(wrReady),
        .dump_start_i(dumpStart), .dump_row_o(dumpRow), .dump_addr_o(dumpAddr),
        .dump_valid_o(dumpValid), .dump_ready_i(dumpReady)
    );

    always #5 clk = ~clk;

    // Element j of row r is v = r*SIZE + j + salt*10000, stored as {imag = -v, real = v}.
    function automatic logic [ROW_W-1:0] makeRow(input int r, input int salt);
        logic [ROW_W-1:0] row;
        logic [63:0]      v;
        row = '0;
        for (int j = 0; j < SIZE; j++) begin
            v = 64'(r * SIZE + j + salt * 10000);
            row[j*128 +: 128] = {-v, v};
        end
        return row;
    endfunction

    function automatic resp_t mkResp(input int a, input logic [ROW_W-1:0] d);
        resp_t e;
        e.addr = AW'(a);
        e.data = d;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkRowOutput(input string name, input logic [ROW_W-1:0] actual, input logic [ROW_W-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got low word %h expected low word %h (rows differ)",
                     name, actual[63:0], expected[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        flush       = 1'b0;
        loadRowIn   = '0;
        loadValid   = 1'b0;
        rdAddr      = '0;
        rdAddrValid = 1'b0;
        wrRow       = '0;
        wrAddr      = '0;
        wrValid     = 1'b0;
        dumpStart   = 1'b0;
        dumpReady   = 1'b0;
    endtask

    task automatic loadRow(input int r, input logic [ROW_W-1:0] row);
        model[r]  = row;
        loadValid = 1'b1;
        loadRowIn = row;
        tick();
        loadValid = 1'b0;
    endtask

    task automatic readRow(input int a);
        rdAddrValid = 1'b1;
        rdAddr      = AW'(a);
        rdQ.push_back(mkResp(a, model[a]));
        tick();
    endtask

    task automatic startDump();
        dumpStart = 1'b1;
        for (int i = 0; i < SIZE; i++) dumpQ.push_back(mkResp(i, model[i]));
        tick();
        dumpStart = 1'b0;
    endtask

    // Drives dump_ready, holding it low for stallCycles cycles while row stallRow is presented.
    task automatic runDump(input int stallRow, input int stallCycles);
        int hs;
        int stalls;
        int budget;
        hs = 0;
        stalls = 0;
        budget = 0;
        while (hs < SIZE && budget < 200) begin
            if (dumpValid && int'(dumpAddr) == stallRow && stalls < stallCycles) begin
                dumpReady = 1'b0;
                checkOutput("dumpHoldAddr", 64'(dumpAddr), 64'(stallRow));
                checkRowOutput("dumpHoldData", dumpRow, model[stallRow]);
                stalls++;
            end else begin
                dumpReady = 1'b1;
            end
            if (dumpValid && dumpReady) hs++;
            tick();
            budget++;
        end
        dumpReady = 1'b0;
        checkOutput("dumpHandshakes", 64'(hs), 64'(SIZE));
    endtask

    // Monitor: every response the DUT presents must match the head of its queue.
    initial begin
        forever begin
            resp_t e;
            @(negedge clk);
            if (matRowValid === 1'b1) begin
                if (rdQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL readUnexpected: got response addr=%0d expected none", matRowAddr);
                end else begin
                    e = rdQ.pop_front();
                    checkOutput("readAddr", 64'(matRowAddr), 64'(e.addr));
                    checkRowOutput("readData", matRow, e.data);
                end
            end
            if (dumpValid === 1'b1 && dumpReady === 1'b1) begin
                if (dumpQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL dumpUnexpected: got row addr=%0d expected none", dumpAddr);
                end else begin
                    e = dumpQ.pop_front();
                    checkOutput("dumpAddr", 64'(dumpAddr), 64'(e.addr));
                    checkRowOutput("dumpData", dumpRow, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish within 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstFull", 64'(full), 0);
        checkOutput("rstMatValid", 64'(matRowValid), 0);
        checkOutput("rstMatRow", 64'(|matRow), 0);
        checkOutput("rstMatAddr", 64'(matRowAddr), 0);
        checkOutput("rstWrReady", 64'(wrReady), 0);
        checkOutput("rstDumpValid", 64'(dumpValid), 0);
        checkOutput("rstDumpRow", 64'(|dumpRow), 0);
        checkOutput("rstDumpAddr", 64'(dumpAddr), 0);
        checkOutput("rstLoadReady", 64'(loadReady), 1);
        rstN = 1'b1;
        tick();

        $display("[TB] wrong-state read/write in IDLE");
        rdAddrValid = 1'b1;
        rdAddr      = 5'd3;
        wrValid     = 1'b1;
        wrAddr      = 5'd3;
        wrRow       = '1;
        checkOutput("idleWrReady", 64'(wrReady), 0);
        tick();
        applyStimulus();
        tick();
        tick();
        checkOutput("idleLoadReady", 64'(loadReady), 1);
        checkOutput("idleFull", 64'(full), 0);

        $display("[TB] contiguous load");
        for (int r = 0; r < SIZE; r++) begin
            if (r == SIZE - 1) checkOutput("fullBeforeLast", 64'(full), 0);
            loadRow(r, makeRow(r, 0));
        end
        checkOutput("fullAfterLoad", 64'(full), 1);
        checkOutput("serveLoadReadyLow", 64'(loadReady), 0);
        checkOutput("serveWrReady", 64'(wrReady), 1);

        $display("[TB] back-to-back reads");
        for (int a = 0; a < SIZE; a++) readRow(a);
        rdAddrValid = 1'b0;
        tick();
        checkOutput("readQueueDrained", 64'(rdQ.size()), 0);

        $display("[TB] read-before-write on row 5");
        rdAddrValid = 1'b1;
        rdAddr      = 5'd5;
        wrValid     = 1'b1;
        wrAddr      = 5'd5;
        wrRow       = '1;
        rdQ.push_back(mkResp(5, model[5]));
        model[5] = '1;
        tick();
        wrValid = 1'b0;
        rdQ.push_back(mkResp(5, model[5]));
        tick();
        rdAddrValid = 1'b0;
        tick();

        $display("[TB] load attempt in SERVE");
        loadValid = 1'b1;
        loadRowIn = makeRow(7, 9);
        checkOutput("serveLoadReady", 64'(loadReady), 0);
        tick();
        loadValid = 1'b0;
        checkOutput("serveFullKept", 64'(full), 1);

        $display("[TB] dump with same-cycle read/write and stall on row 7");
        rdAddrValid = 1'b1;
        rdAddr      = 5'd12;
        rdQ.push_back(mkResp(12, model[12]));
        wrValid = 1'b1;
        wrAddr  = 5'd9;
        wrRow   = makeRow(9, 5);
        model[9] = makeRow(9, 5);
        rdAddrValid = 1'b1;
        startDump();
        rdAddrValid = 1'b0;
        wrValid     = 1'b0;
        runDump(7, 3);
        checkOutput("dumpEndFull", 64'(full), 0);
        checkOutput("dumpEndValid", 64'(dumpValid), 0);
        checkOutput("dumpEndLoadReady", 64'(loadReady), 1);
        checkOutput("dumpQueueDrained", 64'(dumpQ.size()), 0);

        $display("[TB] toggling load, flush at row 10");
        for (int r = 0; r < 10; r++) begin
            loadRow(r, makeRow(r, 1));
            tick();
        end
        loadValid = 1'b1;
        loadRowIn = makeRow(10, 1);
        flush     = 1'b1;
        tick();
        applyStimulus();
        checkOutput("flushLoadReady", 64'(loadReady), 1);
        checkOutput("flushFull", 64'(full), 0);
        for (int r = 0; r < SIZE; r++) begin
            loadRow(r, makeRow(r, 2));
            if (r < SIZE - 1) tick();
        end
        checkOutput("reloadFull", 64'(full), 1);
        startDump();
        runDump(-1, 0);
        checkOutput("dump2QueueDrained", 64'(dumpQ.size()), 0);

        $display("[TB] flush cancels same-cycle read");
        for (int r = 0; r < SIZE; r++) loadRow(r, makeRow(r, 3));
        readRow(0);
        readRow(31);
        rdAddr = 5'd10;
        flush  = 1'b1;
        tick();
        applyStimulus();
        tick();
        tick();
        checkOutput("flushReadLoadReady", 64'(loadReady), 1);
        checkOutput("flushReadFull", 64'(full), 0);
        checkOutput("flushReadQueue", 64'(rdQ.size()), 0);

        $display("[TB] async reset mid-dump");
        for (int r = 0; r < SIZE; r++) loadRow(r, makeRow(r, 4));
        startDump();
        dumpReady = 1'b1;
        repeat (5) tick();
        rstN = 1'b0;
        #1;
        dumpQ.delete();
        checkOutput("midRstDumpValid", 64'(dumpValid), 0);
        checkOutput("midRstDumpRow", 64'(|dumpRow), 0);
        checkOutput("midRstDumpAddr", 64'(dumpAddr), 0);
        checkOutput("midRstFull", 64'(full), 0);
        checkOutput("midRstMatRow", 64'(|matRow), 0);
        checkOutput("midRstLoadReady", 64'(loadReady), 1);
        applyStimulus();
        tick();
        rstN = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
